// File: rtl/mips_mem_pkg.sv
// ============================================================================
// mips_mem_pkg : opcodes, FSM encoding and helpers for the data-memory unit
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic op_is_valid(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LHU) || (op == OP_LBU) ||
               (op == OP_SW) || (op == OP_SH)  || (op == OP_SB);
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Byte accesses can never be misaligned.
    function automatic logic op_is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        if ((op == OP_LW) || (op == OP_SW))
            return lo != 2'b00;
        if ((op == OP_LHU) || (op == OP_SH))
            return lo[0];
        return 1'b0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_store_lane_aligner.sv
// ============================================================================
// mips_store_lane_aligner : byte enables and lane-replicated write data
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_store_lane_aligner
    import mips_mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    // Loads read the full word; the load path picks the lane afterwards.
    always_comb begin
        be    = 4'b1111;
        wdata = 32'h0;
        case (opcode)
            OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            OP_SH: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
            end
            OP_SW: begin
                wdata = store_data;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_data_mem_access_unit.sv
// ============================================================================
// mips_data_mem_access_unit : multicycle load/store unit with req/ready bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_data_mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [5:0]  load_opcode,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       addr_lo;
    logic [CNT_W-1:0] tcount;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      rd_aligned;
    logic             timeout_hit;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // The count holds the number of earlier stalled cycles, so this cycle is the last allowed one.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcount == CNT_LAST);

    mips_store_lane_aligner u_lane_aligner (
        .opcode     (opcode),
        .addr_lo    (addr[1:0]),
        .store_data (store_data),
        .be         (lane_be),
        .wdata      (lane_wdata)
    );

    always_comb begin
        rd_aligned = 32'h0;
        case (load_opcode)
            OP_LW:   rd_aligned = mem_rdata;
            OP_LHU:  rd_aligned = {16'h0, mem_rdata[{addr_lo[1], 4'b0000} +: 16]};
            OP_LBU:  rd_aligned = {24'h0, mem_rdata[{addr_lo, 3'b000} +: 8]};
            default: rd_aligned = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_lo     <= 2'b00;
            tcount      <= '0;
            done        <= 1'b0;
            load_data   <= 32'h0;
            load_opcode <= 6'h0;
            misaligned  <= 1'b0;
            bus_error   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_be      <= 4'h0;
            mem_wdata   <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && op_is_valid(opcode)) begin
                        load_opcode <= opcode;
                        addr_lo     <= addr[1:0];
                        misaligned  <= 1'b0;
                        bus_error   <= 1'b0;
                        tcount      <= '0;
                        if (op_is_misaligned(opcode, addr[1:0])) begin
                            misaligned <= 1'b1;
                            load_data  <= 32'h0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= op_is_store(opcode);
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= lane_be;
                            mem_wdata <= lane_wdata;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        load_data <= rd_aligned;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        load_data <= 32'h0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_data_mem_access_unit.sv
// ============================================================================
// tb_mips_data_mem_access_unit : vector table, random model checks, reset cases
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_data_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [5:0]  load_opcode;
    logic        misaligned;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    mips_data_mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .opcode      (opcode),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .load_data   (load_data),
        .load_opcode (load_opcode),
        .misaligned  (misaligned),
        .bus_error   (bus_error),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          waits;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
        logic        mis;
        logic        berr;
        int          lat;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    string tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=0x%08h expected=0x%08h", tag, name, act, exp);
        end
    endtask

    // Reference model: derived from access size and byte offset arithmetic.
    function automatic vec_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [31:0] rd,
                                   input int waits);
        vec_t v;
        int   size;
        int   off;
        logic store;
        logic [31:0] mask;
        v.op = op; v.addr = a; v.sdata = sd; v.rdata = rd; v.waits = waits;
        store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        size  = (op == OP_LW || op == OP_SW) ? 4 : (op == OP_LHU || op == OP_SH) ? 2 : 1;
        off   = int'(a % 4);
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
        v.mis = (a % size) != 0;
        v.be  = store ? 4'(((1 << size) - 1) << off) : 4'hF;
        if (size == 1)      v.wdata = {24'h0, sd[7:0]} * 32'h0101_0101;
        else if (size == 2) v.wdata = {16'h0, sd[15:0]} * 32'h0001_0001;
        else                v.wdata = sd;
        v.berr = !v.mis && (waits >= 16);
        v.lat  = v.mis ? 0 : (v.berr ? 16 : waits + 1);
        v.ldata = (v.mis || v.berr || store) ? 32'h0 : ((rd >> (8 * off)) & mask);
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int          req_cycles;
        int          cyc;
        logic        exp_we;
        logic [31:0] exp_addr;
        exp_we   = (v.op == OP_SW) || (v.op == OP_SH) || (v.op == OP_SB);
        exp_addr = v.addr & 32'hFFFF_FFFC;
        req_valid  = 1'b1;
        opcode     = v.op;
        addr       = v.addr;
        store_data = v.sdata;
        mem_ready  = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        addr       = $urandom;
        store_data = $urandom;
        req_cycles = 0;
        cyc        = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (mem_req === 1'b1) begin
                req_cycles++;
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_be", 32'(mem_be), 32'(v.be));
                if (exp_we)
                    chk("mem_wdata", mem_wdata, v.wdata);
            end
            chk("busy", 32'(busy), 32'd1);
            mem_ready = (req_cycles > v.waits);
            mem_rdata = mem_ready ? v.rdata : $urandom;
            @(negedge clk);
            cyc++;
        end
        mem_ready = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'(v.lat));
        chk("req_cycles", 32'(req_cycles), 32'(v.lat));
        chk("mem_req_at_done", 32'(mem_req), 32'd0);
        chk("load_data", load_data, v.ldata);
        chk("load_opcode", 32'(load_opcode), 32'(v.op));
        chk("misaligned", 32'(misaligned), 32'(v.mis));
        chk("bus_error", 32'(bus_error), 32'(v.berr));
        @(negedge clk);
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
        chk("load_data_hold", load_data, v.ldata);
        chk("misaligned_hold", 32'(misaligned), 32'(v.mis));
    endtask

    task automatic check_reset_state();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_load_opcode", 32'(load_opcode), 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
    endtask

    vec_t       table_v[12];
    vec_t       v;
    logic [5:0] ops[6];

    initial begin
        //            op      addr          sdata         rdata         waits be    wdata         ldata         mis   berr  lat
        table_v[0]  = '{OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1};
        table_v[1]  = '{OP_SB,  32'h103, 32'h000000A5, 32'h0,        0,   4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 1};
        table_v[2]  = '{OP_LBU, 32'h202, 32'h0,        32'h11223344, 3,   4'hF, 32'h0,        32'h22,       1'b0, 1'b0, 4};
        table_v[3]  = '{OP_LHU, 32'h201, 32'h0,        32'h55667788, 0,   4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 0};
        table_v[4]  = '{OP_LW,  32'h206, 32'h0,        32'h55667788, 0,   4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 0};
        table_v[5]  = '{OP_LW,  32'h300, 32'h0,        32'h12345678, 100, 4'hF, 32'h0,        32'h0,        1'b0, 1'b1, 16};
        table_v[6]  = '{OP_LW,  32'h304, 32'h0,        32'hCAFEF00D, 15,  4'hF, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 16};
        table_v[7]  = '{OP_SH,  32'h402, 32'h1234BEEF, 32'h0,        1,   4'hC, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0, 2};
        table_v[8]  = '{OP_LHU, 32'h502, 32'h0,        32'hAABBCCDD, 0,   4'hF, 32'h0,        32'h0000AABB, 1'b0, 1'b0, 1};
        table_v[9]  = '{OP_LBU, 32'h501, 32'h0,        32'hAABBCCDD, 2,   4'hF, 32'h0,        32'h000000CC, 1'b0, 1'b0, 3};
        table_v[10] = '{OP_SH,  32'h603, 32'h00001234, 32'h0,        0,   4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 0};
        table_v[11] = '{OP_SW,  32'h702, 32'h00001234, 32'h0,        0,   4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 0};
        ops = '{OP_LW, OP_LHU, OP_LBU, OP_SW, OP_SH, OP_SB};

        rst_n = 1'b0; req_valid = 1'b0; opcode = 6'h0; addr = 32'h0;
        store_data = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
        tag = "reset";
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(table_v[i]);
        end

        for (int i = 0; i < 40; i++) begin
            int w;
            w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
            tag = $sformatf("rand%0d", i);
            v = model(ops[$urandom_range(0, 5)], $urandom, $urandom, $urandom, w);
            run_vec(v);
        end

        // Reset in the middle of a stalled load, after a load left nonzero data behind.
        tag = "mid_reset_pre";
        run_vec(model(OP_LBU, 32'h0000_0803, 32'h0, 32'hF1E2D3C4, 0));
        req_valid = 1'b1; opcode = OP_LW; addr = 32'h900; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        tag = "mid_reset";
        chk("mem_req_before_rst", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state();

        // An unlisted opcode must be ignored.
        tag = "bad_opcode";
        req_valid = 1'b1; opcode = 6'b000000; addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("req_ready", 32'(req_ready), 32'd1);
            chk("busy", 32'(busy), 32'd0);
            chk("mem_req", 32'(mem_req), 32'd0);
            chk("done", 32'(done), 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);

        tag = "recover";
        run_vec(model(OP_SB, 32'h0000_0A01, 32'h0000_003C, 32'h0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_data_mem_access_unit.md
Name: mips_data_mem_access_unit

Overview:
Multicycle load/store unit between the MEM-stage control and a data memory with a req/ready handshake.
- Issues word-aligned memory requests with byte enables and replicates store data onto byte lanes.
- Right-aligns returned load data so bits [15:0] or [7:0] hold the addressed halfword or byte.
- Forwards the latched opcode, ready for the downstream load word/halfword/byte selector and extender.
- Flags misaligned accesses and bus timeouts, and stalls the pipeline while busy.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed in ACCESS without mem_ready before bus_error; 0 disables timeout.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
req_valid  input  1  pipeline requests an access.
req_ready  output  1  unit can accept a request; equals state==IDLE.
opcode  input  6  lw 100011, lhu 100101, lbu 100100, sw 101011, sh 101001, sb 101000.
addr  input  32  byte address.
store_data  input  32  register value to store, right-aligned.
busy  output  1  high in every state except IDLE; used as pipeline stall.
done  output  1  one-cycle completion pulse.
load_data  output  32  right-aligned read data, zero above access width.
load_opcode  output  6  opcode of the completed access.
misaligned  output  1  completed access was misaligned.
bus_error  output  1  completed access timed out.
mem_req  output  1  memory request.
mem_we  output  1  1 = write.
mem_addr  output  32  {addr[31:2],2'b00}.
mem_be  output  4  byte enables; bit i corresponds to data[8i+7:8i] (little-endian lanes).
mem_wdata  output  32  lane-replicated store data.
mem_rdata  input  32  read data, valid when mem_ready=1.
mem_ready  input  1  memory completes the current request this cycle.

Behaviour:
- Reset is synchronous: at any rising edge with rst_n=0, the state goes to IDLE and every registered output clears to 0. This covers load_data, load_opcode, misaligned, bus_error, done, mem_req, mem_we, mem_addr, mem_be, mem_wdata and the timeout counter. Once reset is applied, req_ready=1 and busy=0.
- Reset mid-ACCESS abandons the request; mem_req is low from the following cycle.
- States: IDLE, ACCESS, DONE.
- IDLE: accept when req_valid=1 and opcode is one of the six listed above. Any other opcode is ignored, with no state change and no flag change.
  - On accept, clear misaligned and bus_error, and latch load_opcode and addr[1:0].
- Misaligned means lw/sw with addr[1:0]!=0, or lhu/sh with addr[0]=1. Byte accesses are never misaligned.
  - A misaligned access goes IDLE->DONE with misaligned=1 and load_data=0, and never asserts mem_req.
- An aligned access goes IDLE->ACCESS.
  - mem_req=1 is registered, and mem_we/mem_addr/mem_be/mem_wdata are held stable until the handshake completes.
- Store lanes:
  - sb: mem_be = 4'b0001<<addr[1:0], mem_wdata = {4{store_data[7:0]}}.
  - sh: mem_be = 4'b0011<<addr[1:0], mem_wdata = {2{store_data[15:0]}}.
  - sw: mem_be = 4'b1111, mem_wdata = store_data.
  - Loads: mem_be = 4'b1111, mem_we=0.
- ACCESS, when mem_ready=1 is sampled:
  - Drop mem_req, go to DONE and capture load_data.
  - lw: load_data = mem_rdata.
  - lhu: load_data = {16'h0, mem_rdata[16*addr[1] +: 16]}.
  - lbu: load_data = {24'h0, mem_rdata[8*addr[1:0] +: 8]}.
  - Stores: load_data = 0.
- Timeout: a counter increments each ACCESS cycle without mem_ready. When it reaches TIMEOUT_CYCLES, drop mem_req, set bus_error=1 and load_data=0, and go to DONE.
  - mem_ready high in the same cycle the count reaches the limit counts as success.
- DONE: done=1 for exactly one cycle, then IDLE.
  - load_data, load_opcode, misaligned and bus_error hold until the next accepted request.
- Latency: accept at edge N, mem_req high from N+1. With mem_ready=1 in that cycle, done is high at N+2. A misaligned access has done high at N+1.
- mem_ready sampled outside ACCESS is ignored.
- req_valid during ACCESS/DONE is not accepted; the requester holds it.

Decomposition:
- Package mips_mem_pkg holds:
  - opcode constants OP_LW, OP_LHU, OP_LBU, OP_SW, OP_SH, OP_SB;
  - state encoding (IDLE, ACCESS, DONE);
  - default TIMEOUT_CYCLES.
- One combinational sub-module, mips_store_lane_aligner: (opcode, addr[1:0], store_data) -> (mem_be, mem_wdata). The FSM, timeout counter and load alignment stay in the top module.

Test Plan:
- sw addr=0x100, data=0xDEADBEEF, mem_ready=1 immediately -> mem_be=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF; done 2 cycles after accept.
- sb addr=0x103, data=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- lbu addr=0x202, mem_rdata=0x11223344 after 3 wait cycles -> mem_req held 4 cycles, load_data=0x00000022, load_opcode=100100.
- lhu addr=0x201 -> misaligned=1, done at N+1, mem_req never asserted; lw addr=0x206 likewise.
- lw with mem_ready held low and TIMEOUT_CYCLES=16 -> mem_req low after 16 ACCESS cycles, bus_error=1, load_data=0.
- rst_n=0 for one edge during ACCESS -> next cycle: IDLE, mem_req=0, all flags 0, req_ready=1; an opcode of 000000 with req_valid=1 -> not accepted.
